matrix_result_serializer: RTL and testbench
===========================================

# matrix_result_serializer

Drains packed 2x2 result matrices (four ELEM_W-bit elements, packed {c11, c12, c21, c22}, MSB first) from the multiplier output side and emits them one element per beat on a valid/ready stream. It is the consumer end of the packed-matrix interface: it accepts a whole matrix per input handshake, buffers up to two matrices, and serializes them with row/column tags and a last-element flag for downstream storage or display logic.

## Interface
- ELEM_W, 4, width of one matrix element; input word is 4*ELEM_W bits
- clk  input  1  rising-edge clock; one clock domain
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  packed matrix on in_mat is valid
- in_ready  output  1  block can accept a matrix this cycle
- in_mat  input  4*ELEM_W  packed {c11, c12, c21, c22}, c11 in the top ELEM_W bits
- out_valid  output  1  out_data/out_idx/out_last valid
- out_ready  input  1  downstream accepts the current beat
- out_data  output  ELEM_W  current element
- out_idx  output  2  {row, col} of current element (c11=0, c12=1, c21=2, c22=3)
- out_last  output  1  current beat is the final element of its matrix
- busy  output  1  a matrix is held or pending
- mat_cnt  output  8  count of fully emitted matrices, wraps 255 -> 0

## Operation
- Storage: hold register (matrix being emitted) plus one pend register; flags hold_v, pend_v; 2-bit beat counter beat.
- States: IDLE (hold_v=0) and SEND (hold_v=1). busy = hold_v | pend_v.
- in_ready = !pend_v (combinational from register state only; never depends on in_valid or out_ready).
- Input accept (in_valid & in_ready):
  - IDLE: in_mat -> hold, beat <= 0, go SEND.
  - SEND, final beat transferring this cycle and pend_v=0: in_mat -> hold, beat <= 0, stay SEND.
  - SEND otherwise: in_mat -> pend, pend_v <= 1.
- Output beat transfers when out_valid & out_ready; beat increments; data is never dropped or duplicated.
- Final beat transfer (beat=3): mat_cnt += 1; if pend_v, pend -> hold, pend_v <= 0, beat <= 0, stay SEND; else if input accepted same cycle, load it as above; else go IDLE.
- out_valid = hold_v; out_last = hold_v & (beat==3).
- Element order (row-major): beat 0..3 -> c11, c12, c21, c22, out_idx = 0,1,2,3. out_data = hold slice selected by out_idx.
- Arithmetic: beat and mat_cnt are modulo counters (2 and 8 bits); no saturation.
- Reset (any time, including mid-matrix): hold and pend discarded, hold_v=pend_v=0, beat=0, mat_cnt=0, state IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, mat_cnt=0.
- Latency: matrix accepted at edge k -> first beat valid in the cycle after edge k (1 cycle).
- Throughput: with out_ready held high and input always valid, one element per cycle, 4 cycles per matrix, no bubbles between matrices.
- Backpressure: while out_valid & !out_ready, out_data, out_idx, out_last are stable.
- in_ready falls the cycle after a matrix lands in pend; rises the cycle after pend moves to hold.
- mat_cnt updates on the edge that completes the last beat.

## Configuration
- MATRIX_SER_COL_MAJOR_EN defined: column-major emission, beat 0..3 -> c11, c21, c12, c22, out_idx = 0,2,1,3; out_idx still tags true {row,col}; out_last still on beat 3 (c22).
- Not defined: row-major order as in Operation.

## Test plan
- Reset then in_mat=16'hA5C3 one pulse, out_ready=1 -> beats A,5,C,3, out_idx 0,1,2,3, out_last only on 4th, mat_cnt 0->1, back to IDLE, busy=0.
- Same stimulus with MATRIX_SER_COL_MAJOR_EN -> beats A,C,5,3, out_idx 0,2,1,3, out_last on 3.
- Matrices 16'h1234 and 16'h5678 back-to-back, out_ready=1 -> 8 consecutive beats 1..8 with no gap; mat_cnt=2.
- out_ready=0 with three matrices offered -> first to hold, second to pend, in_ready=0 so third stalls; outputs frozen at 1st element; release out_ready -> all 12 elements in order.
- Random out_ready toggling over 300 matrices -> scoreboard matches every element, mat_cnt wraps to 44.
- Assert rst_n low after 2nd beat of 16'hA5C3 -> out_valid=0, busy=0, mat_cnt=0 immediately; next matrix 16'h0F0F emits 0,F,0,F from beat 0.

Source files
------------

// File: rtl/matrix_result_serializer_if.sv
// matrix_result_serializer_if: packed-matrix input stream, element output stream and status.
// The master modport is the surrounding environment; the slave modport is the serializer.
interface matrix_result_serializer_if #(
    parameter int ELEM_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*ELEM_W-1:0]   in_mat;
    logic                  out_valid;
    logic                  out_ready;
    logic [ELEM_W-1:0]     out_data;
    logic [1:0]            out_idx;
    logic                  out_last;
    logic                  busy;
    logic [7:0]            mat_cnt;

    modport master (
        output in_valid, in_mat, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy, mat_cnt
    );

    modport slave (
        input  in_valid, in_mat, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy, mat_cnt
    );
endinterface

// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer: buffers up to two packed 2x2 matrices and emits one tagged element per beat.
// Define MATRIX_SER_COL_MAJOR_EN to emit in column-major order (c11, c21, c12, c22).
module matrix_result_serializer #(
    parameter int ELEM_W = 4
) (
    input logic                       clk,
    input logic                       rst_n,
    matrix_result_serializer_if.slave bus
);
    localparam int MAT_W = 4 * ELEM_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [MAT_W-1:0]  hold_q, hold_d;
    logic [MAT_W-1:0]  pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic [1:0]        beat_q, beat_d;
    logic [7:0]        mat_cnt_q, mat_cnt_d;

    logic              hold_v;
    logic              in_fire;
    logic              out_fire;
    logic              last_fire;
    logic [1:0]        elem_idx;
    logic [ELEM_W-1:0] elem_data;

    assign hold_v    = (state_q == SEND);
    assign in_fire   = bus.in_valid & ~pend_v_q;
    assign out_fire  = hold_v & bus.out_ready;
    assign last_fire = out_fire & (beat_q == 2'd3);

`ifdef MATRIX_SER_COL_MAJOR_EN
    // Swapping the beat bits walks c11, c21, c12, c22 while still yielding the true {row, col}.
    assign elem_idx = {beat_q[0], beat_q[1]};
`else
    assign elem_idx = beat_q;
`endif

    always_comb begin
        elem_data = hold_q[MAT_W-1 -: ELEM_W];
        case (elem_idx)
            2'd0:    elem_data = hold_q[4*ELEM_W-1 -: ELEM_W];
            2'd1:    elem_data = hold_q[3*ELEM_W-1 -: ELEM_W];
            2'd2:    elem_data = hold_q[2*ELEM_W-1 -: ELEM_W];
            default: elem_data = hold_q[ELEM_W-1 -: ELEM_W];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        beat_d    = beat_q;
        mat_cnt_d = mat_cnt_q;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    hold_d  = bus.in_mat;
                    beat_d  = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_fire) begin
                    beat_d = beat_q + 2'd1;
                end
                if (last_fire) begin
                    mat_cnt_d = mat_cnt_q + 8'd1;
                    // A pending matrix has priority; in_ready is low then, so no input can collide.
                    if (pend_v_q) begin
                        hold_d   = pend_q;
                        pend_v_d = 1'b0;
                        beat_d   = 2'd0;
                    end else if (in_fire) begin
                        hold_d = bus.in_mat;
                        beat_d = 2'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (in_fire) begin
                    pend_d   = bus.in_mat;
                    pend_v_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            beat_q    <= 2'd0;
            mat_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            beat_q    <= beat_d;
            mat_cnt_q <= mat_cnt_d;
        end
    end

    assign bus.in_ready  = ~pend_v_q;
    assign bus.out_valid = hold_v;
    assign bus.out_data  = elem_data;
    assign bus.out_idx   = elem_idx;
    assign bus.out_last  = hold_v & (beat_q == 2'd3);
    assign bus.busy      = hold_v | pend_v_q;
    assign bus.mat_cnt   = mat_cnt_q;
endmodule

// File: tb/tb_matrix_result_serializer.sv
// Self-checking bench for matrix_result_serializer: directed vector table plus multi-cycle sequences.
// Expectations follow MATRIX_SER_COL_MAJOR_EN when it is defined for the build.
module tb_matrix_result_serializer;
    localparam int ELEM_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    matrix_result_serializer_if #(.ELEM_W(ELEM_W)) bus ();

    matrix_result_serializer #(.ELEM_W(ELEM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        iv;
        logic [15:0] mat;
        logic        ordy;
        logic        ov;
        logic [3:0]  data;
        logic [1:0]  idx;
        logic        last;
        logic        ir;
        logic        busy;
        logic [7:0]  cnt;
    } vec_t;

`ifdef MATRIX_SER_COL_MAJOR_EN
    localparam logic [1:0] ORDER [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
`else
    localparam logic [1:0] ORDER [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif

    int          checks = 0;
    int          failures = 0;
    vec_t        tbl [19];
    logic [15:0] src_q [$];
    logic [15:0] exp_q [$];
    int          mdl_beat = 0;

    function automatic vec_t mk(logic iv, logic [15:0] mat, logic ordy, logic ov, logic [3:0] data,
                                logic [1:0] idx, logic last, logic ir, logic busy, logic [7:0] cnt);
        vec_t v;
        v.iv = iv; v.mat = mat; v.ordy = ordy; v.ov = ov; v.data = data;
        v.idx = idx; v.last = last; v.ir = ir; v.busy = busy; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [3:0] model_elem(logic [15:0] m, int k);
        case (ORDER[k])
            2'd0:    return m[15:12];
            2'd1:    return m[11:8];
            2'd2:    return m[7:4];
            default: return m[3:0];
        endcase
    endfunction

    task automatic applyStimulus(input logic iv, input logic [15:0] mat, input logic ordy);
        bus.in_valid  = iv;
        bus.in_mat    = mat;
        bus.out_ready = ordy;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives src_q into the DUT and checks every emitted beat against the queue of accepted matrices.
    task automatic runStream(input bit rand_ready, input int max_cycles, output int fires);
        int   cyc;
        logic rdy;
        bit   in_fire, out_fire;
        cyc   = 0;
        fires = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
            @(negedge clk);
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (src_q.size() > 0) applyStimulus(1'b1, src_q[0], rdy);
            else                  applyStimulus(1'b0, 16'h0, rdy);
            #1;
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            checkOutput("stream_out_valid", 16'(bus.out_valid), 16'(exp_q.size() > 0));
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    checkOutput("stream_spurious_beat", 16'd1, 16'd0);
                end else begin
                    checkOutput("stream_data", 16'(bus.out_data), 16'(model_elem(exp_q[0], mdl_beat)));
                    checkOutput("stream_idx", 16'(bus.out_idx), 16'(ORDER[mdl_beat]));
                    checkOutput("stream_last", 16'(bus.out_last), 16'(mdl_beat == 3));
                end
            end
            @(posedge clk);
            if (out_fire && exp_q.size() > 0) begin
                fires++;
                if (mdl_beat == 3) begin
                    void'(exp_q.pop_front());
                    mdl_beat = 0;
                end else begin
                    mdl_beat++;
                end
            end
            if (in_fire) begin
                exp_q.push_back(src_q.pop_front());
            end
            cyc++;
        end
        if (src_q.size() > 0 || exp_q.size() > 0) begin
            checkOutput("stream_timeout", 16'd1, 16'd0);
        end
        src_q.delete();
        exp_q.delete();
        mdl_beat = 0;
        @(negedge clk);
        applyStimulus(1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        int fires;
        applyStimulus(1'b0, 16'h0, 1'b0);

        // Async reset with no clock edge needed
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", 16'(bus.in_ready), 16'd1);
        checkOutput("rst_out_valid", 16'(bus.out_valid), 16'd0);
        checkOutput("rst_out_data", 16'(bus.out_data), 16'd0);
        checkOutput("rst_out_idx", 16'(bus.out_idx), 16'd0);
        checkOutput("rst_out_last", 16'(bus.out_last), 16'd0);
        checkOutput("rst_busy", 16'(bus.busy), 16'd0);
        checkOutput("rst_mat_cnt", 16'(bus.mat_cnt), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Columns: iv, mat, out_ready | out_valid, data, idx, last, in_ready, busy, mat_cnt
        tbl[0]  = mk(1, 16'hA5C3, 1, 0, 4'h0, 0, 0, 1, 0, 0);
        tbl[5]  = mk(1, 16'h1234, 1, 0, 4'h0, 0, 0, 1, 0, 1);
        tbl[18] = mk(0, 16'h0000, 1, 0, 4'h0, 0, 0, 1, 0, 4);
`ifdef MATRIX_SER_COL_MAJOR_EN
        tbl[1]  = mk(0, 16'h0000, 1, 1, 4'hA, 0, 0, 1, 1, 0);
        tbl[2]  = mk(0, 16'h0000, 1, 1, 4'hC, 2, 0, 1, 1, 0);
        tbl[3]  = mk(0, 16'h0000, 1, 1, 4'h5, 1, 0, 1, 1, 0);
        tbl[4]  = mk(0, 16'h0000, 1, 1, 4'h3, 3, 1, 1, 1, 0);
        tbl[6]  = mk(0, 16'h0000, 1, 1, 4'h1, 0, 0, 1, 1, 1);
        tbl[7]  = mk(0, 16'h0000, 1, 1, 4'h3, 2, 0, 1, 1, 1);
        tbl[8]  = mk(0, 16'h0000, 1, 1, 4'h2, 1, 0, 1, 1, 1);
        tbl[9]  = mk(1, 16'h5678, 1, 1, 4'h4, 3, 1, 1, 1, 1);
        tbl[10] = mk(1, 16'h9ABC, 1, 1, 4'h5, 0, 0, 1, 1, 2);
        tbl[11] = mk(0, 16'h0000, 1, 1, 4'h7, 2, 0, 0, 1, 2);
        tbl[12] = mk(0, 16'h0000, 1, 1, 4'h6, 1, 0, 0, 1, 2);
        tbl[13] = mk(0, 16'h0000, 1, 1, 4'h8, 3, 1, 0, 1, 2);
        tbl[14] = mk(0, 16'h0000, 1, 1, 4'h9, 0, 0, 1, 1, 3);
        tbl[15] = mk(0, 16'h0000, 1, 1, 4'hB, 2, 0, 1, 1, 3);
        tbl[16] = mk(0, 16'h0000, 1, 1, 4'hA, 1, 0, 1, 1, 3);
        tbl[17] = mk(0, 16'h0000, 1, 1, 4'hC, 3, 1, 1, 1, 3);
`else
        tbl[1]  = mk(0, 16'h0000, 1, 1, 4'hA, 0, 0, 1, 1, 0);
        tbl[2]  = mk(0, 16'h0000, 1, 1, 4'h5, 1, 0, 1, 1, 0);
        tbl[3]  = mk(0, 16'h0000, 1, 1, 4'hC, 2, 0, 1, 1, 0);
        tbl[4]  = mk(0, 16'h0000, 1, 1, 4'h3, 3, 1, 1, 1, 0);
        tbl[6]  = mk(0, 16'h0000, 1, 1, 4'h1, 0, 0, 1, 1, 1);
        tbl[7]  = mk(0, 16'h0000, 1, 1, 4'h2, 1, 0, 1, 1, 1);
        tbl[8]  = mk(0, 16'h0000, 1, 1, 4'h3, 2, 0, 1, 1, 1);
        tbl[9]  = mk(1, 16'h5678, 1, 1, 4'h4, 3, 1, 1, 1, 1);
        tbl[10] = mk(1, 16'h9ABC, 1, 1, 4'h5, 0, 0, 1, 1, 2);
        tbl[11] = mk(0, 16'h0000, 1, 1, 4'h6, 1, 0, 0, 1, 2);
        tbl[12] = mk(0, 16'h0000, 1, 1, 4'h7, 2, 0, 0, 1, 2);
        tbl[13] = mk(0, 16'h0000, 1, 1, 4'h8, 3, 1, 0, 1, 2);
        tbl[14] = mk(0, 16'h0000, 1, 1, 4'h9, 0, 0, 1, 1, 3);
        tbl[15] = mk(0, 16'h0000, 1, 1, 4'hA, 1, 0, 1, 1, 3);
        tbl[16] = mk(0, 16'h0000, 1, 1, 4'hB, 2, 0, 1, 1, 3);
        tbl[17] = mk(0, 16'h0000, 1, 1, 4'hC, 3, 1, 1, 1, 3);
`endif

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i].iv, tbl[i].mat, tbl[i].ordy);
            #1;
            checkOutput($sformatf("vec%0d_out_valid", i), 16'(bus.out_valid), 16'(tbl[i].ov));
            if (tbl[i].ov) checkOutput($sformatf("vec%0d_out_data", i), 16'(bus.out_data), 16'(tbl[i].data));
            checkOutput($sformatf("vec%0d_out_idx", i), 16'(bus.out_idx), 16'(tbl[i].idx));
            checkOutput($sformatf("vec%0d_out_last", i), 16'(bus.out_last), 16'(tbl[i].last));
            checkOutput($sformatf("vec%0d_in_ready", i), 16'(bus.in_ready), 16'(tbl[i].ir));
            checkOutput($sformatf("vec%0d_busy", i), 16'(bus.busy), 16'(tbl[i].busy));
            checkOutput($sformatf("vec%0d_mat_cnt", i), 16'(bus.mat_cnt), 16'(tbl[i].cnt));
        end

        // Backpressure: hold and pend fill, third matrix stalls, outputs frozen on the first element
        @(negedge clk);
        applyStimulus(1'b1, 16'h1234, 1'b0);
        #1 checkOutput("bp_in_ready_idle", 16'(bus.in_ready), 16'd1);
        @(negedge clk);
        applyStimulus(1'b1, 16'h5678, 1'b0);
        #1 checkOutput("bp_in_ready_hold", 16'(bus.in_ready), 16'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 16'h9ABC, 1'b0);
            #1;
            checkOutput("bp_in_ready", 16'(bus.in_ready), 16'd0);
            checkOutput("bp_out_valid", 16'(bus.out_valid), 16'd1);
            checkOutput("bp_out_data", 16'(bus.out_data), 16'h1);
            checkOutput("bp_out_idx", 16'(bus.out_idx), 16'd0);
            checkOutput("bp_out_last", 16'(bus.out_last), 16'd0);
            checkOutput("bp_busy", 16'(bus.busy), 16'd1);
        end
        exp_q = '{16'h1234, 16'h5678};
        src_q = '{16'h9ABC};
        mdl_beat = 0;
        runStream(1'b0, 100, fires);
        checkOutput("bp_beats", 16'(fires), 16'd12);
        checkOutput("bp_mat_cnt", 16'(bus.mat_cnt), 16'd7);

        // 300 random matrices with random backpressure from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) src_q.push_back(16'($urandom));
        runStream(1'b1, 20000, fires);
        checkOutput("rand_beats", 16'(fires), 16'd1200);
        checkOutput("rand_mat_cnt_wrap", 16'(bus.mat_cnt), 16'd44);
        checkOutput("rand_busy", 16'(bus.busy), 16'd0);

        // Reset in the middle of a matrix, then a fresh matrix starts from beat 0
        @(negedge clk);
        applyStimulus(1'b1, 16'hA5C3, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0, 1'b1);
        #1 checkOutput("mid_beat0", 16'(bus.out_data), 16'(model_elem(16'hA5C3, 0)));
        @(negedge clk);
        #1 checkOutput("mid_beat1", 16'(bus.out_data), 16'(model_elem(16'hA5C3, 1)));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 16'(bus.out_valid), 16'd0);
        checkOutput("mid_rst_busy", 16'(bus.busy), 16'd0);
        checkOutput("mid_rst_mat_cnt", 16'(bus.mat_cnt), 16'd0);
        checkOutput("mid_rst_in_ready", 16'(bus.in_ready), 16'd1);
        checkOutput("mid_rst_out_last", 16'(bus.out_last), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        src_q = '{16'h0F0F};
        runStream(1'b0, 50, fires);
        checkOutput("post_rst_beats", 16'(fires), 16'd4);
        checkOutput("post_rst_mat_cnt", 16'(bus.mat_cnt), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
